// File: rtl/mem_burst_responder_pkg.sv
// Shared types and constants for the burst memory responder.
package mem_burst_responder_pkg;

  localparam int unsigned ADDR_W              = 21;
  localparam int unsigned DATA_W              = 32;
  localparam int unsigned MASK_W              = DATA_W / 8;
  localparam int unsigned BURST_BEATS_DEFAULT = 8;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    WRITE,
    READ_WAIT,
    READ_BURST
  } resp_state_t;

endpackage

// File: rtl/mem_burst_responder_if.sv
// Frame-buffer memory command bus: controller drives commands, responder returns bursts.
interface mem_burst_responder_if;
  import mem_burst_responder_pkg::*;

  logic              cmd;
  logic              cmd_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [MASK_W-1:0] data_mask;
  logic [DATA_W-1:0] rd_data;
  logic              rd_data_valid;
  logic              init_done;
  logic              busy;
  logic              error;

  modport master (
    output cmd, cmd_en, addr, wr_data, data_mask,
    input  rd_data, rd_data_valid, init_done, busy, error
  );

  modport slave (
    input  cmd, cmd_en, addr, wr_data, data_mask,
    output rd_data, rd_data_valid, init_done, busy, error
  );
endinterface

// File: rtl/mem_bsram_bytewise.sv
// Single-port 32-bit BSRAM with byte write enables and a read-first registered output.
module mem_bsram_bytewise
  import mem_burst_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 4096
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic [MASK_W-1:0]        we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        q
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      q <= mem[addr];
      for (int b = 0; b < int'(MASK_W); b++) begin
        if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/mem_burst_responder.sv
// Fixed-latency 8-beat burst responder backed by on-chip BSRAM.
module mem_burst_responder
  import mem_burst_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS  = 4096,
  parameter int unsigned BURST_BEATS  = BURST_BEATS_DEFAULT,
  parameter int unsigned READ_LATENCY = 5,
  parameter int unsigned INIT_CYCLES  = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mem_burst_responder_if.slave bus
);

  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam int unsigned BEAT_W = $clog2(BURST_BEATS);
  localparam int unsigned LAT_W  = $clog2(READ_LATENCY + 1);
  localparam int unsigned INIT_W = $clog2(INIT_CYCLES);

  resp_state_t       state, state_nxt;
  logic [INIT_W-1:0] init_cnt;
  logic [LAT_W-1:0]  lat_cnt;
  logic [BEAT_W-1:0] beat_cnt;
  logic [IDX_W-1:0]  ptr;
  logic              rd_pend;
  logic [DATA_W-1:0] ram_q;

  logic [IDX_W-1:0]  cmd_idx_c;
  logic              init_last_c, lat_last_c, wr_last_c, rd_last_c;
  logic              ram_en_c, rd_issue_c, cmd_err_c;
  logic [MASK_W-1:0] ram_we_c;
  logic [IDX_W-1:0]  ram_addr_c;
  logic              unused_c;

  assign cmd_idx_c   = bus.addr[IDX_W:1];
  assign unused_c    = ^{bus.addr[0], bus.addr[ADDR_W-1:IDX_W+1]};
  assign init_last_c = (init_cnt == INIT_W'(INIT_CYCLES - 1));
  assign lat_last_c  = (lat_cnt == LAT_W'(READ_LATENCY - 1));
  assign wr_last_c   = (beat_cnt == BEAT_W'(BURST_BEATS - 1));
  assign rd_last_c   = (beat_cnt == BEAT_W'(BURST_BEATS - 2));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= INIT;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:       if (init_last_c) state_nxt = IDLE;
      IDLE:       if (bus.cmd_en) state_nxt = (bus.cmd == CMD_WRITE) ? WRITE : READ_WAIT;
      WRITE:      if (wr_last_c) state_nxt = IDLE;
      READ_WAIT:  if (lat_last_c) state_nxt = READ_BURST;
      READ_BURST: if (rd_last_c) state_nxt = IDLE;
      default:    state_nxt = INIT;
    endcase
  end

  // Reads are issued two edges ahead of rd_data: one for the RAM register, one for the output register.
  always_comb begin
    ram_en_c   = 1'b0;
    ram_we_c   = '0;
    ram_addr_c = ptr;
    rd_issue_c = 1'b0;
    cmd_err_c  = 1'b0;
    case (state)
      INIT: cmd_err_c = bus.cmd_en;
      IDLE: begin
        if (bus.cmd_en && bus.cmd == CMD_WRITE) begin
          ram_en_c   = 1'b1;
          ram_we_c   = ~bus.data_mask;
          ram_addr_c = cmd_idx_c;
        end
      end
      WRITE: begin
        ram_en_c  = 1'b1;
        ram_we_c  = ~bus.data_mask;
        cmd_err_c = bus.cmd_en;
      end
      READ_WAIT: begin
        rd_issue_c = (lat_cnt >= LAT_W'(READ_LATENCY - 2));
        ram_en_c   = rd_issue_c;
        cmd_err_c  = bus.cmd_en;
      end
      READ_BURST: begin
        rd_issue_c = (beat_cnt < BEAT_W'(BURST_BEATS - 2));
        ram_en_c   = rd_issue_c;
        cmd_err_c  = bus.cmd_en;
      end
      default: ;
    endcase
  end

  // Counters and the shared word pointer (write beats and read issue share it).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      init_cnt <= '0;
      lat_cnt  <= '0;
      beat_cnt <= '0;
      ptr      <= '0;
    end else begin
      case (state)
        INIT: if (!init_last_c) init_cnt <= init_cnt + INIT_W'(1);
        IDLE: begin
          lat_cnt <= '0;
          if (bus.cmd_en) begin
            ptr      <= (bus.cmd == CMD_WRITE) ? cmd_idx_c + IDX_W'(1) : cmd_idx_c;
            beat_cnt <= (bus.cmd == CMD_WRITE) ? BEAT_W'(1) : '0;
          end
        end
        WRITE: begin
          ptr      <= ptr + IDX_W'(1);
          beat_cnt <= beat_cnt + BEAT_W'(1);
        end
        READ_WAIT: begin
          lat_cnt <= lat_cnt + LAT_W'(1);
          if (rd_issue_c) ptr <= ptr + IDX_W'(1);
        end
        READ_BURST: begin
          beat_cnt <= beat_cnt + BEAT_W'(1);
          if (rd_issue_c) ptr <= ptr + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend           <= 1'b0;
      bus.rd_data       <= '0;
      bus.rd_data_valid <= 1'b0;
      bus.init_done     <= 1'b0;
      bus.busy          <= 1'b0;
      bus.error         <= 1'b0;
    end else begin
      rd_pend           <= rd_issue_c;
      bus.rd_data_valid <= rd_pend;
      if (rd_pend) bus.rd_data <= ram_q;
      bus.init_done     <= (state_nxt != INIT);
      bus.busy          <= (state_nxt == WRITE) || (state_nxt == READ_WAIT) ||
                           (state_nxt == READ_BURST);
      bus.error         <= bus.error | cmd_err_c;
    end
  end

  mem_bsram_bytewise #(
    .DEPTH (DEPTH_WORDS)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en_c),
    .we    (ram_we_c),
    .addr  (ram_addr_c),
    .wdata (bus.wr_data),
    .q     (ram_q)
  );

endmodule

// File: doc/mem_burst_responder.md
Name: mem_burst_responder

Overview:
- Synthesizable responder side of the frame-buffer memory command interface. It answers VideoController-style cmd/cmd_en/addr requests with fixed-latency 8-beat bursts, backed by an on-chip 32-bit-wide BSRAM array.
- Stands in for the PSRAM/SDRAM controller in small-frame builds (e.g. a 23x17 LCD path) and in closed-loop benches without a behavioural memory model.
- Supports both read bursts and write bursts, with per-byte masking on writes.

Parameters:
- DEPTH_WORDS, 4096: backing array depth in 32-bit words; must be a power of 2.
- BURST_BEATS, 8: 32-bit beats per command; 16 halfwords per burst.
- READ_LATENCY, 5: clk edges from the cmd_en sample edge to the first rd_data_valid edge; minimum 2.
- INIT_CYCLES, 16: cycles after reset release before init_done rises.

Ports:
- clk  in  1  controller clock (fb_clk domain)
- reset_n  in  1  asynchronous active-low reset
- cmd  in  1  command type: 1 = write, 0 = read
- cmd_en  in  1  single-cycle command strobe
- addr  in  21  halfword address; addr[0] is ignored
- wr_data  in  32  write beat data
- data_mask  in  4  byte mask; 1 = byte NOT written
- rd_data  out  32  read beat data
- rd_data_valid  out  1  read beat qualifier
- init_done  out  1  responder ready
- busy  out  1  burst in progress
- error  out  1  sticky protocol error

Behaviour:
- Reset: asynchronous reset (reset_n low, active-low) on clock clk. While in reset: rd_data = 0, rd_data_valid = 0, init_done = 0, busy = 0, error = 0, FSM = INIT. Array contents are not cleared.
- Word index: word_idx = addr[20:1] + beat, truncated to log2(DEPTH_WORDS) bits. Wrap-around inside the array is silent.
- Beat packing: beat j carries {halfword 2j+1 [31:16], halfword 2j [15:0]}, relative to addr with addr[0] cleared.
- INIT state:
  - Counter runs 0..INIT_CYCLES-1.
  - init_done is registered and rises on the edge after the count reaches INIT_CYCLES-1, then stays high until reset.
  - cmd_en seen in INIT sets error; no other action.
- IDLE state:
  - busy = 0.
  - cmd_en=1 with cmd=1: go to WRITE. Beat 0 is written from wr_data/data_mask in the same edge, so write data accompanies cmd_en.
  - cmd_en=1 with cmd=0: latch base index, go to READ_WAIT.
- WRITE state:
  - Beats 1..BURST_BEATS-1 are taken on the next consecutive edges, one per cycle, with no backpressure.
  - Byte b of the word is written only when data_mask[b] = 0.
  - After the last beat, return to IDLE.
- READ_WAIT state:
  - A latency counter issues the BSRAM reads so that, with cmd_en sampled at edge T, rd_data_valid = 1 after edges T+READ_LATENCY through T+READ_LATENCY+BURST_BEATS-1.
  - This gives exactly 8 consecutive valid cycles, and rd_data changes only at those edges.
- READ_BURST state:
  - Emits beats in order.
  - After the last beat, rd_data_valid = 0 and the FSM returns to IDLE.
  - rd_data holds the last beat value until the next burst.
- busy: 1 from the edge that accepts the command until the FSM returns to IDLE. A new command is accepted on the first cycle busy = 0, so back-to-back commands are legal with zero idle gap.
- cmd_en while busy:
  - The command is dropped and error is set.
  - The current burst continues unaffected.
  - error clears only on reset.
- Read-after-write: a read issued on the cycle after the final write beat returns the newly written data; the BSRAM is read-first with no bypass needed, given the latency.
- Reset asserted mid-burst: the burst aborts immediately, rd_data_valid drops asynchronously, and partially written beats stay in the array.
- Beat counter is log2(BURST_BEATS) bits wide; latency counter is ceil(log2(READ_LATENCY+1)) bits wide.

Decomposition:
- Package MemResponderTypes holds:
  - enum RespState_t {INIT, IDLE, WRITE, READ_WAIT, READ_BURST};
  - CMD_READ = 1'b0 and CMD_WRITE = 1'b1;
  - localparam BURST_BEATS_DEFAULT = 8.
- One sub-module, mem_bsram_bytewise: single-port 32-bit RAM with 4 byte-write enables and a registered read port. The responder FSM is the top level.

Test Plan:
- Reset release -> init_done = 0 for 16 cycles, then 1. All other outputs stay 0 throughout.
- Write burst at addr 0x000020 with wr_data 0x00010000+j (j=0..7), mask 0 -> read at 0x000020 returns 0x00010000..0x00010007. rd_data_valid is high for exactly 8 cycles, starting 5 edges after cmd_en.
- Write 0xFFFFFFFF at addr 0x40, then write 0x12345678 with mask 4'b0101 -> readback beat 0 = 0x12FF56FF.
- Read at addr 0x21 -> same data as a read at 0x20 (addr[0] ignored). Read at index DEPTH_WORDS-4 -> beats 4..7 wrap to words 0..3.
- cmd_en pulsed 3 cycles into a read -> error = 1, the original 8 beats are delivered intact, and no second burst appears.
- Back-to-back read commands issued on the first busy = 0 cycle -> 16 valid beats, separated by the latency gap only. reset_n pulsed low mid-burst -> rd_data_valid = 0 at once and init_done restarts its count.
